xor_multiport_regfile: RTL and testbench
========================================

Name: xor_multiport_regfile

Overview:
- Parametrised successor to the two-write/four-read XOR-banked integer register file used by the superscalar core.
- Provides NW write ports and NR read ports over NREG entries of DATA_W bits.
- Uses one storage bank per write port; the architectural value of an entry is the XOR of all banks at that index.
- Adds what the current register file lacks: defined same-address write priority, a sequential post-reset clear engine with a busy flag, an optional hardwired zero register, and optional write-to-read bypass.

Parameters:
- DATA_W, 32, entry width in bits.
- NREG, 32, number of entries; power of two, at least 2. Localparam AW = $clog2(NREG).
- NW, 2, write ports; 1 to 4. One bank per port.
- NR, 4, read ports; 1 to 8.
- ZERO_REG, 1, when 1 entry 0 always reads 0 and writes to it are dropped.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- raddr  in  NR*AW  read addresses; port r uses bits [r*AW +: AW].
- rdata  out  NR*DATA_W  read data; port r uses bits [r*DATA_W +: DATA_W]. Combinational.
- we  in  NW  per-port write enable.
- waddr  in  NW*AW  write addresses; port w uses bits [w*AW +: AW].
- wdata  in  NW*DATA_W  write data; port w uses bits [w*DATA_W +: DATA_W].
- busy  out  1  high while the clear engine runs; writes are ignored while high.

Behaviour:
- Storage: banks bank[0..NW-1], each NREG x DATA_W.
  - Read value V(a) = XOR over k of bank[k][a].
  - Effective write on port w: bank[w][waddr_w] <= wdata_w ^ (XOR of bank[k][waddr_w] for all k != w), using pre-edge bank contents.
  - After the edge, V(waddr_w) = wdata_w.
- Write conflict: if enabled ports share an address in the same cycle, the highest-indexed port wins. Lower-indexed ports to that address are suppressed (their bank is not written). This keeps the XOR invariant intact.
- ZERO_REG=1:
  - Writes with waddr=0 are suppressed.
  - Reads with raddr=0 return 0 regardless of bank contents.
- Read latency: 0 cycles (combinational). A write becomes visible to reads on the cycle after its clock edge, unless bypass is compiled in.
- Clear engine, two states, CLEAR and RUN:
  - rst_n=0 at a clock edge: state<=CLEAR, clr_idx<=0, busy<=1. Reset value of busy is 1.
  - CLEAR with rst_n=1: every bank at clr_idx is written 0 and clr_idx increments.
  - When clr_idx = NREG-1 is cleared, state<=RUN and busy<=0.
  - Clear therefore takes NREG cycles after reset release.
  - During CLEAR, all rdata are forced to 0 and all we are ignored.
  - rst_n low mid-clear restarts the clear from index 0.
  - RUN: normal operation; remains in RUN until the next reset.
- clr_idx wraps only through reset. It is AW+1 bits internally, so NREG-1 is detected without overflow.
- Initial (simulation time 0) bank contents are don't-care; the clear engine establishes zeros.

Optional Feature:
- Macro: XOR_REGFILE_BYPASS_EN.
- Defined:
  - In RUN, when a read address matches an enabled, non-suppressed write address in the same cycle, rdata returns that port's wdata combinationally.
  - Priority follows the write-conflict rule: the highest matching port wins.
  - ZERO_REG masking still applies to address 0.
  - No bypass during CLEAR.
- Undefined: reads return pre-edge storage only; a same-cycle write is seen one cycle later.

Test Plan:
- Reset clear: hold rst_n=0 for 3 cycles, release. busy=1 for exactly 32 cycles, then 0. Every raddr 0..31 then reads 0x00000000.
- Dual write: port0 writes 5<-0xDEADBEEF and port1 writes 6<-0x12345678 in the same cycle. Next cycle raddr 5/6/5/6 reads 0xDEADBEEF/0x12345678/0xDEADBEEF/0x12345678.
- Conflict: port0 and port1 both write 9, with 0xAAAA0000 and 0x0000BBBB. Reg 9 reads 0x0000BBBB. Then port0 alone writes 9<-0x1. Reg 9 reads 0x00000001, confirming the XOR invariant survived.
- Zero register (ZERO_REG=1): port1 writes 0<-0xFFFFFFFF. Reg 0 reads 0; other registers are unchanged.
- Reset mid-clear: pull rst_n low at clear cycle 10 for 1 cycle. busy then stays high for a further 32 cycles after release. Writes attempted while busy have no effect.
- Bypass: with XOR_REGFILE_BYPASS_EN, write 3<-0xCAFEF00D while raddr=3 in the same cycle; rdata shows 0xCAFEF00D that cycle. Without the macro, it shows the old value (0) that cycle and 0xCAFEF00D the next.

Source files
------------

// File: rtl/xor_multiport_regfile.sv
// xor_multiport_regfile
//   Multi-port register file built from one storage bank per write port.
//   The value of an entry is the XOR of every bank at that index, so each
//   write port only ever touches its own bank and no bank needs more than
//   one write port.
//
//   Ports
//     clk    in   rising-edge clock
//     rst_n  in   synchronous active-low reset; restarts the clear engine
//     raddr  in   NR*AW      read address, port r at [r*AW +: AW]
//     rdata  out  NR*DATA_W  read data (combinational), port r at [r*DATA_W +: DATA_W]
//     we     in   NW         per-port write enable
//     waddr  in   NW*AW      write address, port w at [w*AW +: AW]
//     wdata  in   NW*DATA_W  write data, port w at [w*DATA_W +: DATA_W]
//     busy   out  1          high while the clear engine runs; writes ignored
//
//   Build option
//     XOR_REGFILE_BYPASS_EN  when defined, a read that matches a same-cycle
//                            accepted write returns that write's data.
//
//   State   | meaning
//   --------+---------------------------------------------------------------
//   CLEAR   | zeroing one index per cycle in every bank; reads 0, busy high
//   RUN     | normal read/write operation until the next reset

module xor_multiport_regfile #(
  parameter int DATA_W   = 32,
  parameter int NREG     = 32,
  parameter int NW       = 2,
  parameter int NR       = 4,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NR*$clog2(NREG)-1:0] raddr,
  output logic [NR*DATA_W-1:0] rdata,
  input  logic [NW-1:0]        we,
  input  logic [NW*$clog2(NREG)-1:0] waddr,
  input  logic [NW*DATA_W-1:0] wdata,
  output logic                 busy
);

  localparam int AW = $clog2(NREG);
  // One extra bit so the last index is reached without wrapping.
  localparam logic [AW:0] LAST_IDX = (AW+1)'(NREG - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [AW:0]       r_clr_idx;
  logic [AW:0]       w_clr_idx_nxt;

  logic [DATA_W-1:0] r_bank [NW][NREG];

  logic [AW-1:0]     w_waddr [NW];
  logic [DATA_W-1:0] w_wdata [NW];
  logic [DATA_W-1:0] w_wval  [NW];
  logic [NW-1:0]     w_wr_en;
  logic [AW-1:0]     w_raddr [NR];
  logic [DATA_W-1:0] w_rval  [NR];

  assign busy = (r_state == ST_CLEAR);

  // ---------------------------------------------------------------------
  // Clear engine
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    case (r_state)
      ST_CLEAR: begin
        w_clr_idx_nxt = r_clr_idx + (AW+1)'(1);
        if (r_clr_idx == LAST_IDX) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_CLEAR;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------
  always_comb begin
    for (int w = 0; w < NW; w++) begin
      w_waddr[w] = waddr[w*AW +: AW];
      w_wdata[w] = wdata[w*DATA_W +: DATA_W];
    end
  end

  // A port is dropped when a higher-indexed enabled port targets the same
  // entry; only one bank changes per entry, which keeps the XOR of banks
  // equal to the winning data.
  always_comb begin
    for (int w = 0; w < NW; w++) begin
      w_wr_en[w] = we[w] && (r_state == ST_RUN) &&
                   !((ZERO_REG != 0) && (w_waddr[w] == '0));
      for (int j = 0; j < NW; j++) begin
        if ((j > w) && we[j] && (w_waddr[j] == w_waddr[w])) begin
          w_wr_en[w] = 1'b0;
        end
      end
    end
  end

  // Store data pre-XORed with the other banks so the full XOR yields wdata.
  always_comb begin
    for (int w = 0; w < NW; w++) begin
      w_wval[w] = w_wdata[w];
      for (int k = 0; k < NW; k++) begin
        if (k != w) begin
          w_wval[w] = w_wval[w] ^ r_bank[k][w_waddr[w]];
        end
      end
    end
  end

  // Bank contents have no reset value; the clear engine zeroes them.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (r_state == ST_CLEAR) begin
        for (int k = 0; k < NW; k++) begin
          r_bank[k][r_clr_idx[AW-1:0]] <= '0;
        end
      end else begin
        for (int w = 0; w < NW; w++) begin
          if (w_wr_en[w]) begin
            r_bank[w][w_waddr[w]] <= w_wval[w];
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read side
  // ---------------------------------------------------------------------
  always_comb begin
    rdata = '0;
    for (int r = 0; r < NR; r++) begin
      w_raddr[r] = raddr[r*AW +: AW];
      w_rval[r]  = '0;
      for (int k = 0; k < NW; k++) begin
        w_rval[r] = w_rval[r] ^ r_bank[k][w_raddr[r]];
      end
`ifdef XOR_REGFILE_BYPASS_EN
      // Ascending scan: the highest matching port overrides. w_wr_en is
      // already low during CLEAR and for suppressed writes.
      for (int w = 0; w < NW; w++) begin
        if (w_wr_en[w] && (w_waddr[w] == w_raddr[r])) begin
          w_rval[r] = w_wdata[w];
        end
      end
`endif
      if ((r_state == ST_CLEAR) || ((ZERO_REG != 0) && (w_raddr[r] == '0))) begin
        w_rval[r] = '0;
      end
      rdata[r*DATA_W +: DATA_W] = w_rval[r];
    end
  end

endmodule

// File: tb/tb_xor_multiport_regfile.sv
// tb_xor_multiport_regfile
//   Randomised and directed bench for xor_multiport_regfile with default
//   parameters. A plain array of architectural register values serves as the
//   reference; the bank/XOR structure of the design is not modelled.
//   Honours XOR_REGFILE_BYPASS_EN when compiled with it.

module tb_xor_multiport_regfile;

  localparam int DW   = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int NW   = 2;
  localparam int NR   = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR*AW-1:0]  raddr;
  logic [NR*DW-1:0]  rdata;
  logic [NW-1:0]     we;
  logic [NW*AW-1:0]  waddr;
  logic [NW*DW-1:0]  wdata;
  logic              busy;

  always #5 clk = ~clk;

  xor_multiport_regfile #(
    .DATA_W(DW), .NREG(NREG), .NW(NW), .NR(NR), .ZERO_REG(1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata),
    .we(we), .waddr(waddr), .wdata(wdata), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: architectural value per entry plus clear progress.
  logic [DW-1:0] m_reg [NREG];
  bit            m_busy = 1'b1;
  int            m_clr  = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(logic [AW-1:0] a);
    logic [DW-1:0] v;
    if (m_busy || a == '0) return '0;
    v = m_reg[a];
`ifdef XOR_REGFILE_BYPASS_EN
    for (int w = 0; w < NW; w++)
      if (we[w] && waddr[w*AW +: AW] == a) v = wdata[w*DW +: DW];
`endif
    return v;
  endfunction

  // Apply one clock edge to the reference using the inputs present at it.
  task automatic model_edge();
    if (!rst_n) begin
      m_busy = 1'b1;
      m_clr  = 0;
    end else if (m_busy) begin
      m_reg[m_clr] = '0;
      m_clr++;
      if (m_clr == NREG) m_busy = 1'b0;
    end else begin
      // Ascending order: later (higher) ports overwrite earlier ones.
      for (int w = 0; w < NW; w++)
        if (we[w] && waddr[w*AW +: AW] != '0)
          m_reg[waddr[w*AW +: AW]] = wdata[w*DW +: DW];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_all(string tag);
    #2;
    chk({tag, "_busy"}, 32'(busy), 32'(m_busy));
    for (int r = 0; r < NR; r++)
      chk($sformatf("%s_rd%0d", tag, r), rdata[r*DW +: DW], exp_rd(raddr[r*AW +: AW]));
  endtask

  task automatic rand_writes();
    we = NW'($urandom);
    for (int w = 0; w < NW; w++) begin
      waddr[w*AW +: AW] = AW'($urandom_range(0, NREG-1));
      wdata[w*DW +: DW] = $urandom;
    end
  endtask

  task automatic read_all_zero(string tag);
    for (int a = 0; a < NREG; a += NR) begin
      for (int r = 0; r < NR; r++) raddr[r*AW +: AW] = AW'(a + r);
      check_all(tag);
      for (int r = 0; r < NR; r++)
        chk($sformatf("%s_z%0d", tag, a + r), rdata[r*DW +: DW], 32'h0);
      tick();
    end
  endtask

  int cnt;

  initial begin
    rst_n = 1'b0; we = '0; waddr = '0; wdata = '0; raddr = '0;
    for (int i = 0; i < NREG; i++) m_reg[i] = '0;

    // Reset and full clear
    repeat (3) tick();
    check_all("rst");
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      #2;
      if (!busy) break;
      cnt++;
      tick();
    end
    chk("clr_len", cnt, 32);
    read_all_zero("clr");

    // Dual write
    we = 2'b11; waddr = {5'd6, 5'd5}; wdata = {32'h12345678, 32'hDEADBEEF};
    raddr = {5'd6, 5'd5, 5'd6, 5'd5};
    check_all("dual_w");
    tick();
    we = '0;
    check_all("dual_r");
    chk("dual_p0", rdata[0*DW +: DW], 32'hDEADBEEF);
    chk("dual_p1", rdata[1*DW +: DW], 32'h12345678);
    chk("dual_p2", rdata[2*DW +: DW], 32'hDEADBEEF);
    chk("dual_p3", rdata[3*DW +: DW], 32'h12345678);
    tick();

    // Same-address conflict, then single write to check the invariant
    we = 2'b11; waddr = {5'd9, 5'd9}; wdata = {32'h0000BBBB, 32'hAAAA0000};
    raddr = {5'd9, 5'd9, 5'd9, 5'd9};
    check_all("conf_w");
    tick();
    we = '0;
    check_all("conf_r");
    chk("conf_r9", rdata[0*DW +: DW], 32'h0000BBBB);
    tick();
    we = 2'b01; waddr = {5'd9, 5'd9}; wdata = {32'h0, 32'h1};
    tick();
    we = '0;
    check_all("conf_inv");
    chk("conf_inv9", rdata[0*DW +: DW], 32'h00000001);
    tick();

    // Zero register
    we = 2'b10; waddr = {5'd0, 5'd0}; wdata = {32'hFFFFFFFF, 32'h0};
    tick();
    we = '0; raddr = {5'd9, 5'd6, 5'd5, 5'd0};
    check_all("zero");
    chk("zero_r0", rdata[0*DW +: DW], 32'h0);
    chk("zero_r5", rdata[1*DW +: DW], 32'hDEADBEEF);
    chk("zero_r6", rdata[2*DW +: DW], 32'h12345678);
    chk("zero_r9", rdata[3*DW +: DW], 32'h00000001);
    tick();

    // Same-cycle read of a write
    we = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'h0, 32'hCAFEF00D};
    raddr = {5'd0, 5'd0, 5'd0, 5'd3};
    check_all("byp");
`ifdef XOR_REGFILE_BYPASS_EN
    chk("byp_same", rdata[0*DW +: DW], 32'hCAFEF00D);
`else
    chk("byp_same", rdata[0*DW +: DW], 32'h0);
`endif
    tick();
    we = '0;
    check_all("byp_nxt");
    chk("byp_next", rdata[0*DW +: DW], 32'hCAFEF00D);
    tick();

    // Random traffic, biased toward address collisions on port 1
    for (int i = 0; i < 400; i++) begin
      rand_writes();
      if (i % 2 == 0) waddr[1*AW +: AW] = waddr[0*AW +: AW];
      for (int r = 0; r < NR; r++)
        raddr[r*AW +: AW] = (r < NW && i % 3 == 0) ? waddr[r*AW +: AW]
                                                    : AW'($urandom_range(0, NREG-1));
      check_all("rnd");
      tick();
    end

    // Reset mid-clear with writes attempted while busy
    we = '0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rand_writes();
      check_all("mc");
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      rand_writes();
      #2;
      if (!busy) break;
      cnt++;
      tick();
    end
    we = '0;
    chk("mc_len", cnt, 32);
    read_all_zero("mc");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
